// File: rtl/gpu_link_pkg.sv
// Shared definitions for the scheduler->core broadcast link.
//  WORD_W      : frame length, instruction / mask / R0 width
//  tag_e       : frame type, latched on the first bit of each frame
//  STB_*       : bit positions of the val_* strobes in the packed strobe vector,
//                ordered {val_R0, val_mask_ac, val_mask_R0, val_ins} as on the scheduler side
//  stb_to_tag  : maps a one-hot strobe vector to its frame tag
package gpu_link_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_INS,
        TAG_MASK_R0,
        TAG_MASK_AC,
        TAG_R0
    } tag_e;

    localparam int NUM_STB     = 4;
    localparam int STB_INS     = 0;
    localparam int STB_MASK_R0 = 1;
    localparam int STB_MASK_AC = 2;
    localparam int STB_R0      = 3;

    // Only meaningful for a one-hot input; anything else maps to TAG_NONE.
    function automatic tag_e stb_to_tag(input logic [NUM_STB-1:0] stb);
        tag_e t;
        t = TAG_NONE;
        case (stb)
            4'b0001: t = TAG_INS;
            4'b0010: t = TAG_MASK_R0;
            4'b0100: t = TAG_MASK_AC;
            4'b1000: t = TAG_R0;
            default: t = TAG_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Synchronous FIFO with combinational head read.
//  clk, reset : clock, synchronous active-high reset
//  push/wdata : write request; accepted when not full, or when full and popping
//  pop/rdata  : read request (ignored when empty); rdata is the current head
//  count      : occupancy 0..DEPTH
//  full/empty : occupancy flags
module gpu_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_acc, pop_acc;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_acc  = pop && !empty;
    // A full FIFO may still take a push in the cycle it is popped.
    assign push_acc = push && (!full || pop_acc);
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_core_instr_rx.sv
// Per-core receiver of the scheduler broadcast link: deserialises 1-bit frames
// tagged by the val_* strobes, filters masks by core_id, queues instructions.
//  clk, reset         : clock, synchronous active-high reset
//  core_id            : static core index, selects this core's mask bit
//  instruction        : serial data, MSB first
//  val_ins/val_mask_R0/val_mask_ac/val_R0 : per-bit frame type strobes
//  rtr                : registered "a full instruction frame fits" back to scheduler
//  ins_valid/ins_data/ins_ready : instruction FIFO head handshake
//  active             : core enable from the last active-mask frame
//  r0_valid/r0_data   : one-cycle R0 delivery pulse, data held until next delivery
//  proto_err          : sticky protocol error flag
module gpu_core_instr_rx
    import gpu_link_pkg::*;
#(
    parameter int WORD_W     = gpu_link_pkg::WORD_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        core_id,
    input  logic              instruction,
    input  logic              val_ins,
    input  logic              val_mask_R0,
    input  logic              val_mask_ac,
    input  logic              val_R0,
    output logic              rtr,
    output logic              ins_valid,
    output logic [WORD_W-1:0] ins_data,
    input  logic              ins_ready,
    output logic              active,
    output logic              r0_valid,
    output logic [WORD_W-1:0] r0_data,
    output logic              proto_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    logic [NUM_STB-1:0] stb;
    tag_e               tag, cur_tag;
    logic [WORD_W-2:0]  shift;
    logic [BIT_W-1:0]   bit_cnt;
    logic               mask_r0;
    logic [WORD_W-1:0]  word;
    logic               stb_one, multi, gap, restart, last;
    logic               commit_ins, pop, push_ok, overflow;
    logic [CNT_W-1:0]   count, cnt_nxt;
    logic               full, empty;

    assign stb = {val_R0, val_mask_ac, val_mask_R0, val_ins};

    always_comb begin
        cur_tag    = stb_to_tag(stb);
        stb_one    = (stb != '0) && ((stb & (stb - 1'b1)) == '0);
        multi      = (stb != '0) && !stb_one;
        gap        = (stb == '0) && (bit_cnt != '0);
        // A different tag mid-frame restarts capture with this bit as bit 0.
        restart    = stb_one && (bit_cnt != '0) && (cur_tag != tag);
        last       = stb_one && !restart && (bit_cnt == LAST_BIT);
        word       = {shift, instruction};
        commit_ins = last && (cur_tag == TAG_INS);
        pop        = ins_ready && !empty;
        push_ok    = commit_ins && (!full || pop);
        overflow   = commit_ins && full && !pop;
        cnt_nxt    = count + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            tag       <= TAG_NONE;
            mask_r0   <= 1'b0;
            active    <= 1'b0;
            r0_valid  <= 1'b0;
            r0_data   <= '0;
            proto_err <= 1'b0;
            rtr       <= 1'b1;
        end else begin
            r0_valid <= 1'b0;
            rtr      <= (cnt_nxt < CNT_W'(FIFO_DEPTH));
            if (multi || gap || restart || overflow) proto_err <= 1'b1;

            if (multi || gap) begin
                bit_cnt <= '0;
                tag     <= TAG_NONE;
            end else if (stb_one) begin
                shift <= word[WORD_W-2:0];
                if (restart) begin
                    bit_cnt <= BIT_W'(1);
                    tag     <= cur_tag;
                end else if (last) begin
                    bit_cnt <= '0;
                    tag     <= TAG_NONE;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == '0) tag <= cur_tag;
                end
            end

            if (last) begin
                case (cur_tag)
                    TAG_MASK_R0: mask_r0 <= word[core_id];
                    TAG_MASK_AC: active  <= word[core_id];
                    TAG_R0: if (mask_r0) begin
                        r0_data  <= word;
                        r0_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    gpu_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (commit_ins),
        .wdata (word),
        .pop   (pop),
        .rdata (ins_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign ins_valid = !empty;

endmodule
